// File: rtl/arduino_jugada_rx.sv
// Receives a move (column 0..6) from the Arduino over a raw column code and strobe.
// Both are synchronized, the strobe is debounced on press and on release, and one pulse is raised per press.
module arduino_jugada_rx #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] col_in,
  input  logic       valida_in,
  input  logic       turno_arduino,
  output logic [2:0] col_out,
  output logic       jugada_valida,
  output logic       col_invalida,
  output logic       ocupado
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] DEBOUNCE     = 2'd1;
  localparam logic [1:0] EMIT         = 2'd2;
  localparam logic [1:0] WAIT_RELEASE = 2'd3;

  logic          v_meta, v_s;
  logic [2:0]    c_meta, c_s;
  logic [1:0]    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    col_cap, col_cap_next;
  logic          accept;
  logic          emit_ok;
  logic          emit_bad;

  // Two-flop synchronizers; the first stage may go metastable, so nothing else reads it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_meta <= 1'b0;
      v_s    <= 1'b0;
      c_meta <= 3'd0;
      c_s    <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous stage's old value.
      v_meta <= valida_in;
      v_s    <= v_meta;
      c_meta <= col_in;
      c_s    <= c_meta;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_next   = state;
    cnt_next     = cnt;
    col_cap_next = col_cap;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        if (v_s) begin
          col_cap_next = c_s;
          cnt_next     = '0;
          state_next   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!v_s) begin
          state_next = IDLE;
        end else if (c_s != col_cap) begin
          col_cap_next = c_s;
          cnt_next     = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = EMIT;
          cnt_next   = '0;
          accept     = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      EMIT: begin
        state_next = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (v_s) begin
          cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Pulses are decided on the edge that enters EMIT so they line up with the EMIT cycle.
  assign emit_bad = accept && (col_cap == 3'd7);
  assign emit_ok  = accept && (col_cap != 3'd7) && turno_arduino;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      col_cap       <= 3'd0;
      col_out       <= 3'd0;
      jugada_valida <= 1'b0;
      col_invalida  <= 1'b0;
      ocupado       <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      col_cap       <= col_cap_next;
      jugada_valida <= emit_ok;
      col_invalida  <= emit_bad;
      ocupado       <= (state_next != IDLE);
      if (emit_ok) begin
        col_out <= col_cap;
      end
    end
  end

endmodule

// File: tb/tb_arduino_jugada_rx.sv
// Self-checking bench for arduino_jugada_rx: directed scenarios plus random stimulus,
// compared every cycle against a run-length model of press/release behaviour.
module tb_arduino_jugada_rx;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] col_in = 3'd0;
  logic       valida_in = 1'b0;
  logic       turno_arduino = 1'b0;
  logic [2:0] col_out;
  logic       jugada_valida;
  logic       col_invalida;
  logic       ocupado;

  arduino_jugada_rx #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk          (clk),
    .reset        (reset),
    .col_in       (col_in),
    .valida_in    (valida_in),
    .turno_arduino(turno_arduino),
    .col_out      (col_out),
    .jugada_valida(jugada_valida),
    .col_invalida (col_invalida),
    .ocupado      (ocupado)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int pulse_cnt = 0;
  int inval_cnt = 0;
  int last_pulse = -1;
  int last_inval = -1;

  // Reference model: inputs seen through a two-edge delay; a press is accepted once the
  // same column has been seen high for DC+1 consecutive edges, a release after DC low edges.
  bit       m_v1, m_v2;
  bit [2:0] m_c1, m_c2;
  int       m_mode;   // 0 looking for press, 1 emit cycle, 2 awaiting release
  int       m_run;
  int       m_zeros;
  bit [2:0] m_cap;
  bit       m_jv, m_ci, m_busy;
  bit [2:0] m_col;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    m_v1 = 0; m_v2 = 0; m_c1 = 0; m_c2 = 0;
    m_mode = 0; m_run = 0; m_zeros = 0; m_cap = 0;
    m_jv = 0; m_ci = 0; m_busy = 0; m_col = 0;
  endtask

  task automatic model_edge();
    bit       v;
    bit [2:0] c;
    v = m_v2;
    c = m_c2;
    m_jv = 0;
    m_ci = 0;
    case (m_mode)
      0: begin
        if (v) begin
          if (m_run > 0 && c == m_cap) m_run++;
          else begin
            m_run = 1;
            m_cap = c;
          end
        end else begin
          m_run = 0;
        end
        if (m_run == DC + 1) begin
          m_mode = 1;
          m_run = 0;
          if (m_cap == 3'd7) m_ci = 1;
          else if (turno_arduino) begin
            m_jv = 1;
            m_col = m_cap;
          end
        end
      end
      1: begin
        m_mode = 2;
        m_zeros = 0;
      end
      default: begin
        if (v) m_zeros = 0;
        else m_zeros++;
        if (m_zeros == DC) m_mode = 0;
      end
    endcase
    m_busy = (m_mode != 0) || (m_run > 0);
    m_v2 = m_v1; m_v1 = valida_in;
    m_c2 = m_c1; m_c1 = col_in;
  endtask

  task automatic compare_outputs();
    check("jugada_valida", jugada_valida, m_jv);
    check("col_invalida", col_invalida, m_ci);
    check("col_out", col_out, m_col);
    check("ocupado", ocupado, m_busy);
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    if (reset) model_reset();
    else model_edge();
    #1;
    compare_outputs();
    if (jugada_valida === 1'b1) begin
      pulse_cnt++;
      last_pulse = edge_n;
    end
    if (col_invalida === 1'b1) begin
      inval_cnt++;
      last_inval = edge_n;
    end
  endtask

  // Asynchronous reset asserted mid-cycle, held across one edge, released after it.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    step();
    reset = 1'b0;
  endtask

  task automatic release_strobe();
    valida_in = 1'b0;
    repeat (DC + 4) step();
  endtask

  int e;
  int p0;
  int i0;
  int rst_edge;
  bit seen;

  initial begin
    model_reset();

    // Reset state
    #1;
    compare_outputs();
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
    check("idle_ocupado", ocupado, 1'b0);

    // Stable press of column 3 on the Arduino's turn, held long
    col_in = 3'd3;
    turno_arduino = 1'b1;
    p0 = pulse_cnt;
    valida_in = 1'b1;
    e = edge_n + 1;
    repeat (25) step();
    check("latency_pulse_edge", last_pulse, e + 2 + DC);
    check("held_single_pulse", pulse_cnt - p0, 1);
    check("col_out_after_3", col_out, 3'd3);
    release_strobe();
    check("released_idle", ocupado, 1'b0);

    // Short glitch on the strobe
    p0 = pulse_cnt;
    valida_in = 1'b1;
    repeat (3) step();
    valida_in = 1'b0;
    repeat (4) step();
    check("glitch_no_pulse", pulse_cnt - p0, 0);
    check("glitch_back_idle", ocupado, 1'b0);

    // Column code 7
    p0 = pulse_cnt;
    i0 = inval_cnt;
    col_in = 3'd7;
    valida_in = 1'b1;
    e = edge_n + 1;
    repeat (10) step();
    check("inval_one_pulse", inval_cnt - i0, 1);
    check("inval_pulse_edge", last_inval, e + 2 + DC);
    check("inval_no_valid", pulse_cnt - p0, 0);
    check("inval_col_hold", col_out, 3'd3);
    release_strobe();

    // Press on the other player's turn is discarded, the next one counts
    p0 = pulse_cnt;
    turno_arduino = 1'b0;
    col_in = 3'd5;
    valida_in = 1'b1;
    repeat (10) step();
    check("off_turn_col_hold", col_out, 3'd3);
    release_strobe();
    turno_arduino = 1'b1;
    col_in = 3'd2;
    valida_in = 1'b1;
    repeat (10) step();
    check("turn_one_pulse", pulse_cnt - p0, 1);
    check("turn_col_out", col_out, 3'd2);
    release_strobe();

    // Column changes during debounce: counter restarts, two cycles extra latency
    p0 = pulse_cnt;
    col_in = 3'd1;
    valida_in = 1'b1;
    e = edge_n + 1;
    step();
    step();
    col_in = 3'd4;
    repeat (14) step();
    check("restart_one_pulse", pulse_cnt - p0, 1);
    check("restart_pulse_edge", last_pulse, e + 2 + DC + 2);
    check("restart_col_out", col_out, 3'd4);
    release_strobe();

    // Reset during debounce with the strobe held
    col_in = 3'd6;
    valida_in = 1'b1;
    repeat (4) step();
    check("debounce_busy", ocupado, 1'b1);
    pulse_reset();
    rst_edge = edge_n;
    check("reset_col_out", col_out, 3'd0);
    p0 = pulse_cnt;
    repeat (12) step();
    check("post_reset_pulse_edge", last_pulse, rst_edge + DC + 3);
    check("post_reset_one_pulse", pulse_cnt - p0, 1);
    check("post_reset_col_out", col_out, 3'd6);
    release_strobe();

    // Reset asserted while the pulse is high
    col_in = 3'd0;
    valida_in = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (jugada_valida === 1'b1) seen = 1;
    end
    check("emit_reached", seen, 1'b1);
    pulse_reset();
    check("reset_kills_pulse", jugada_valida, 1'b0);
    release_strobe();

    // Random stimulus against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) valida_in = ~valida_in;
      if ($urandom_range(0, 15) == 0) col_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) turno_arduino = ~turno_arduino;
      if ($urandom_range(0, 599) == 0) pulse_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
